// File: rtl/fetch_arbiter.sv
// fetch_arbiter: shares one RAM read port between bg, fg, sprite and CPU
// fetchers. One transaction in flight at a time. Priority follows the raster
// window, and a starvation guard forces a CPU grant after repeated losses.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no transaction; arbitrate, latch owner/address on a request
// S_ISSUE | mem_cs high for this single cycle
// S_WAIT  | waiting for mem_valid or the timeout abort
module fetch_arbiter #(
  parameter int AW         = 20,
  parameter int DW         = 16,
  parameter int CPU_STARVE = 15,
  parameter int TIMEOUT    = 63
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             hbl,
  input  logic             vbl,
  input  logic [3:0]       req,
  input  logic [4*AW-1:0]  addr,
  output logic [3:0]       ack,
  output logic [DW-1:0]    rdata,
  output logic             err,
  output logic             busy,
  output logic [1:0]       owner,
  output logic             mem_cs,
  output logic [AW-1:0]    mem_addr,
  input  logic             mem_valid,
  input  logic [DW-1:0]    mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [7:0] STARVE_LIM = 8'(CPU_STARVE);
  // Abort fires in the TIMEOUT-th WAIT cycle; the counter holds the number of
  // WAIT cycles already spent, so that cycle sees TIMEOUT-1.
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    starve_cnt;
  logic [7:0]    tmo_cnt;
  logic [AW-1:0] addr_arr [4];
  logic          win_vld;
  logic [1:0]    win_idx;
  logic          cpu_forced;
  logic          tmo_hit;
  logic          done_ok;
  logic          done_tmo;

  for (genvar gi = 0; gi < 4; gi++) begin : g_addr
    assign addr_arr[gi] = addr[gi*AW +: AW];
  end

  // Winner selection: starvation override first, then the raster-window order.
  always_comb begin
    win_vld    = |req;
    win_idx    = 2'd0;
    cpu_forced = req[3] && (starve_cnt >= STARVE_LIM);
    if (cpu_forced) begin
      win_idx = 2'd3;
    end else if (vbl) begin
      if (req[3])      win_idx = 2'd3;
      else if (req[2]) win_idx = 2'd2;
      else if (req[0]) win_idx = 2'd0;
      else             win_idx = 2'd1;
    end else if (hbl) begin
      if (req[2])      win_idx = 2'd2;
      else if (req[0]) win_idx = 2'd0;
      else if (req[1]) win_idx = 2'd1;
      else             win_idx = 2'd3;
    end else begin
      if (req[0])      win_idx = 2'd0;
      else if (req[1]) win_idx = 2'd1;
      else if (req[2]) win_idx = 2'd2;
      else             win_idx = 2'd3;
    end
  end

  // Next-state decode; a data return in the abort cycle still wins.
  always_comb begin
    state_nxt = state;
    done_ok   = 1'b0;
    done_tmo  = 1'b0;
    tmo_hit   = (tmo_cnt == TMO_LAST);
    case (state)
      S_IDLE:  if (win_vld) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (mem_valid) begin
          done_ok   = 1'b1;
          state_nxt = S_IDLE;
        end else if (tmo_hit) begin
          done_tmo  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Registered outputs: grant capture, strobe, completion pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack      <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
      owner    <= 2'd0;
      mem_cs   <= 1'b0;
      mem_addr <= '0;
      rdata    <= '0;
    end else begin
      ack    <= '0;
      err    <= 1'b0;
      mem_cs <= 1'b0;
      busy   <= (state_nxt != S_IDLE);
      if (state == S_IDLE && win_vld) begin
        owner    <= win_idx;
        mem_addr <= addr_arr[win_idx];
        mem_cs   <= 1'b1;
      end
      if (done_ok) begin
        rdata <= mem_rdata;
        ack   <= 4'b0001 << owner;
      end
      if (done_tmo) begin
        ack <= 4'b0001 << owner;
        err <= 1'b1;
      end
    end
  end

  // Timeout counter: zeroed during ISSUE so WAIT starts from 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               tmo_cnt <= '0;
    else if (state == S_ISSUE)  tmo_cnt <= '0;
    else if (state == S_WAIT)   tmo_cnt <= tmo_cnt + 8'd1;
  end

  // CPU starvation counter: counts lost arbitrations, saturates at 255.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (!req[3]) begin
      starve_cnt <= '0;
    end else if (state == S_IDLE && win_vld) begin
      if (win_idx == 2'd3)          starve_cnt <= '0;
      else if (starve_cnt != 8'hFF) starve_cnt <= starve_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_fetch_arbiter.sv
// Directed bench for fetch_arbiter with a small latency-programmable memory
// model and per-requester auto-drop of req on ack.
module tb_fetch_arbiter;

  localparam int AW         = 20;
  localparam int DW         = 16;
  localparam int CPU_STARVE = 15;
  localparam int TIMEOUT    = 63;

  logic            clk;
  logic            reset_n;
  logic            hbl;
  logic            vbl;
  logic [3:0]      req;
  logic [4*AW-1:0] addr;
  logic [3:0]      ack;
  logic [DW-1:0]   rdata;
  logic            err;
  logic            busy;
  logic [1:0]      owner;
  logic            mem_cs;
  logic [AW-1:0]   mem_addr;
  logic            mem_valid;
  logic [DW-1:0]   mem_rdata;

  fetch_arbiter #(
    .AW(AW), .DW(DW), .CPU_STARVE(CPU_STARVE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .hbl(hbl), .vbl(vbl),
    .req(req), .addr(addr), .ack(ack), .rdata(rdata), .err(err),
    .busy(busy), .owner(owner), .mem_cs(mem_cs), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] a_tab [4];
  int            checks;
  int            failures;
  int            cyc;
  bit            mem_en;
  int            mem_lat;
  int            mem_cnt;
  bit            inj_valid;
  logic [3:0]    drop_mask;

  int            cs_cyc [$];
  logic [AW-1:0] cs_adr [$];
  logic [3:0]    ack_q  [$];
  logic [DW-1:0] rd_q   [$];
  logic          err_q  [$];
  logic [1:0]    own_q  [$];
  int            ack_cy [$];

  function automatic logic [DW-1:0] exp_rd(int i);
    return 16'h5A00 ^ a_tab[i][15:0];
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ack_at(int i);
    if (i < ack_q.size()) return 32'(ack_q[i]);
    return 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] rd_at(int i);
    if (i < rd_q.size()) return 32'(rd_q[i]);
    return 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] err_at(int i);
    if (i < err_q.size()) return 32'(err_q[i]);
    return 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] own_at(int i);
    if (i < own_q.size()) return 32'(own_q[i]);
    return 32'hFFFF_FFFF;
  endfunction
  function automatic int ackc_at(int i);
    if (i < ack_cy.size()) return ack_cy[i];
    return -1000;
  endfunction
  function automatic int cs_at(int i);
    if (i < cs_cyc.size()) return cs_cyc[i];
    return -1000;
  endfunction
  function automatic logic [31:0] csa_at(int i);
    if (i < cs_adr.size()) return 32'(cs_adr[i]);
    return 32'hFFFF_FFFF;
  endfunction

  // One clock: observe outputs 1ns after the edge, then drive this cycle's inputs.
  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    mem_valid = 1'b0;
    mem_rdata = '0;
    if (inj_valid) begin
      mem_valid = 1'b1;
      mem_rdata = 16'hBEEF;
      inj_valid = 1'b0;
    end
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        mem_valid = 1'b1;
        mem_rdata = 16'h5A00 ^ mem_addr[15:0];
      end
    end
    if (mem_cs && mem_en) mem_cnt = mem_lat;
    if (mem_cs) begin
      cs_cyc.push_back(cyc);
      cs_adr.push_back(mem_addr);
    end
    if (ack != 4'b0000) begin
      ack_q.push_back(ack);
      rd_q.push_back(rdata);
      err_q.push_back(err);
      own_q.push_back(owner);
      ack_cy.push_back(cyc);
      req = req & ~(ack & drop_mask);
    end
  endtask

  task automatic wait_acks(int n, int budget);
    int k = 0;
    while (ack_q.size() < n && k < budget) begin
      cycle();
      k++;
    end
    chk("ack_count", ack_q.size(), n);
  endtask

  task automatic wait_cs(int n, int budget);
    int k = 0;
    while (cs_cyc.size() < n && k < budget) begin
      cycle();
      k++;
    end
    chk("cs_count", cs_cyc.size(), n);
  endtask

  initial begin
    int ba, bc, t0, c1, c2;
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    mem_en    = 1'b1;
    mem_lat   = 2;
    mem_cnt   = 0;
    inj_valid = 1'b0;
    drop_mask = 4'hF;
    reset_n   = 1'b0;
    hbl       = 1'b0;
    vbl       = 1'b0;
    req       = 4'b0000;
    mem_valid = 1'b0;
    mem_rdata = '0;
    a_tab[0]  = 20'h1_0010;
    a_tab[1]  = 20'h2_0020;
    a_tab[2]  = 20'h3_0030;
    a_tab[3]  = 20'h4_0040;
    addr      = {a_tab[3], a_tab[2], a_tab[1], a_tab[0]};

    repeat (3) cycle();
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_cs", mem_cs, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_rdata", rdata, 0);
    reset_n = 1'b1;
    repeat (2) cycle();

    // Active display, all four requesting, memory latency 2.
    ba = ack_q.size(); bc = cs_cyc.size(); t0 = cyc;
    req = 4'b1111;
    wait_acks(ba + 4, 40);
    chk("act_first_cs", cs_at(bc), t0 + 1);
    chk("act_first_ack", ackc_at(ba), t0 + 4);
    for (int i = 0; i < 4; i++) begin
      chk("act_ack", ack_at(ba + i), 32'(1 << i));
      chk("act_owner", own_at(ba + i), i);
      chk("act_rdata", rd_at(ba + i), exp_rd(i));
      chk("act_err", err_at(ba + i), 0);
      chk("act_maddr", csa_at(bc + i), a_tab[i]);
    end
    for (int i = 1; i < 4; i++)
      chk("act_cs_gap", cs_at(bc + i) - cs_at(bc + i - 1), 4);
    cycle();
    chk("act_idle_busy", busy, 0);

    // Horizontal blank: spr > bg > fg.
    ba = ack_q.size();
    hbl = 1'b1;
    req = 4'b0111;
    wait_acks(ba + 3, 40);
    chk("hbl_ack0", ack_at(ba), 4'b0100);
    chk("hbl_ack1", ack_at(ba + 1), 4'b0001);
    chk("hbl_ack2", ack_at(ba + 2), 4'b0010);

    // Vertical blank (hbl also high): cpu > spr > bg > fg.
    ba = ack_q.size();
    vbl = 1'b1;
    req = 4'b1111;
    wait_acks(ba + 4, 40);
    chk("vbl_ack0", ack_at(ba), 4'b1000);
    chk("vbl_ack1", ack_at(ba + 1), 4'b0100);
    chk("vbl_ack2", ack_at(ba + 2), 4'b0001);
    chk("vbl_ack3", ack_at(ba + 3), 4'b0010);
    hbl = 1'b0;
    vbl = 1'b0;

    // Starvation: bg/fg/cpu hold req continuously; cpu wins every 16th.
    ba = ack_q.size();
    mem_lat = 1;
    drop_mask = 4'h0;
    req = 4'b1011;
    wait_acks(ba + 32, 200);
    req = 4'b0000;
    drop_mask = 4'hF;
    c1 = -1; c2 = -1;
    for (int i = 0; i < 32; i++) begin
      if (ack_at(ba + i) == 32'h8) begin
        if (c1 < 0) c1 = i;
        else if (c2 < 0) c2 = i;
      end
    end
    chk("starve_first_cpu", c1, 15);
    chk("starve_second_cpu", c2, 31);
    chk("starve_first_bg", ack_at(ba), 4'b0001);
    repeat (3) cycle();

    // Normal fg read to set a known rdata, then a timed-out bg read.
    mem_lat = 2;
    ba = ack_q.size();
    req = 4'b0010;
    wait_acks(ba + 1, 20);
    chk("pre_tmo_rdata", rd_at(ba), exp_rd(1));
    mem_en = 1'b0;
    ba = ack_q.size(); bc = cs_cyc.size();
    req = 4'b0001;
    wait_acks(ba + 1, TIMEOUT + 20);
    chk("tmo_ack", ack_at(ba), 4'b0001);
    chk("tmo_err", err_at(ba), 1);
    chk("tmo_rdata_kept", rd_at(ba), exp_rd(1));
    chk("tmo_latency", ackc_at(ba) - cs_at(bc), TIMEOUT + 1);
    inj_valid = 1'b1;
    repeat (4) cycle();
    chk("late_valid_no_ack", ack_q.size(), ba + 1);
    chk("late_valid_rdata", rdata, exp_rd(1));
    chk("late_valid_busy", busy, 0);

    // Data returning in the abort cycle completes normally.
    mem_en = 1'b1;
    mem_lat = TIMEOUT;
    ba = ack_q.size(); bc = cs_cyc.size();
    req = 4'b0100;
    wait_acks(ba + 1, TIMEOUT + 20);
    chk("edge_err", err_at(ba), 0);
    chk("edge_rdata", rd_at(ba), exp_rd(2));
    chk("edge_latency", ackc_at(ba) - cs_at(bc), TIMEOUT + 1);

    // spr drops req during WAIT: ack still delivered.
    mem_lat = 3;
    ba = ack_q.size(); bc = cs_cyc.size();
    req = 4'b0100;
    wait_cs(bc + 1, 10);
    cycle();
    req = 4'b0000;
    wait_acks(ba + 1, 20);
    chk("drop_wait_ack", ack_at(ba), 4'b0100);

    // fg withdraws before being granted: only bg is served.
    ba = ack_q.size(); bc = cs_cyc.size();
    req = 4'b0011;
    wait_cs(bc + 1, 10);
    req[1] = 1'b0;
    wait_acks(ba + 1, 20);
    repeat (6) cycle();
    chk("withdraw_ack", ack_at(ba), 4'b0001);
    chk("withdraw_nacks", ack_q.size(), ba + 1);
    chk("withdraw_ncs", cs_cyc.size(), bc + 1);

    // Reset during WAIT with a memory return still pending.
    mem_lat = 5;
    bc = cs_cyc.size();
    req = 4'b0010;
    wait_cs(bc + 1, 10);
    cycle();
    reset_n = 1'b0;
    #1;
    chk("mrst_ack", ack, 0);
    chk("mrst_err", err, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_owner", owner, 0);
    chk("mrst_cs", mem_cs, 0);
    chk("mrst_maddr", mem_addr, 0);
    chk("mrst_rdata", rdata, 0);
    req = 4'b0000;
    ba = ack_q.size();
    repeat (2) cycle();
    reset_n = 1'b1;
    repeat (6) cycle();
    chk("mrst_stale_no_ack", ack_q.size(), ba);
    mem_lat = 2;
    req = 4'b0001;
    wait_acks(ba + 1, 20);
    chk("mrst_next_ack", ack_at(ba), 4'b0001);
    chk("mrst_next_rdata", rd_at(ba), exp_rd(0));
    chk("mrst_next_err", err_at(ba), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
